cpu_trace_monitor: RTL and testbench
====================================

CPU_TRACE_MONITOR -- requirements
Module: cpu_trace_monitor

Interface
Parameters:
REQ-001 The block SHALL have parameter DW, default 32, meaning the width of pc, instr, reg_data and trace data.
REQ-002 The block SHALL have parameter NREG, default 32, meaning the number of register-file entries dumped.
REQ-003 The block SHALL have parameter RSW, default 5, meaning the reg_sel width, with 2^RSW >= NREG.
REQ-004 The block SHALL have parameter HALT_PC, default 32'h00000048, meaning the PC value that ends the run.
REQ-005 The block SHALL have parameter MAX_CYCLES, default 1000, meaning the timeout limit in clocks.
REQ-006 The block SHALL have parameter TRACE_EN, default 1, meaning per-cycle PC streaming is enabled during RUN when set to 1.
Ports (name, direction, width, meaning):
REQ-007 The block SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-008 The block SHALL have port rstn, input, 1, the reset; reset SHALL be asynchronous and active-low.
REQ-009 The block SHALL have port pc, input, DW, the CPU's current program counter.
REQ-010 The block SHALL have port instr, input, DW, the CPU's current instruction.
REQ-011 The block SHALL have port reg_data, input, DW, the register-file read data; it SHALL be combinational from reg_sel.
REQ-012 The block SHALL have port reg_sel, output, RSW, the register-file read index.
REQ-013 The block SHALL have port cpu_hold, output, 1, which freezes the CPU (clock enable low) when 1.
REQ-014 The block SHALL have port trace_valid, output, 1, the record-valid flag.
REQ-015 The block SHALL have port trace_ready, input, 1, the sink-ready flag.
REQ-016 The block SHALL have port trace_tag, output, 2, the record type: 00 PC, 01 REG, 10 STAT.
REQ-017 The block SHALL have port trace_data, output, DW, the record payload.
REQ-018 The block SHALL have port trace_aux, output, DW, the record auxiliary field.
REQ-019 The block SHALL have port done, output, 1, the sticky run-complete flag.
REQ-020 The block SHALL have port timeout, output, 1, the sticky flag indicating the end cause was timeout.
REQ-021 The block SHALL have port drop_cnt, output, 16, the count of PC records dropped; it SHALL saturate at 16'hFFFF.

Function
REQ-022 The block SHALL implement the states RUN, DUMP, STAT, DONE.
REQ-023 The block SHALL hold the trace output as a single registered slot; a record SHALL transfer on the rising edge where trace_valid=1 and trace_ready=1.
REQ-024 The block SHALL treat the slot as loadable in a cycle where trace_valid=0, or where trace_valid=1 and trace_ready=1; back-to-back transfers SHALL be supported.
REQ-025 The block SHALL hold trace_tag, trace_data and trace_aux stable while trace_valid=1 and trace_ready=0.
REQ-026 In RUN, cycle_cnt (32-bit, internal) SHALL increment once per clock.
REQ-027 In RUN with TRACE_EN=1, each clock SHALL present the PC record {tag 00, data pc, aux instr}.
REQ-028 If the slot is not loadable when a PC record is presented, that record SHALL be dropped, drop_cnt SHALL increment by 1, and the held record SHALL be unchanged.
REQ-029 In RUN with TRACE_EN=0, no PC records SHALL be produced and drop_cnt SHALL stay 0.
REQ-030 In RUN, pc==HALT_PC SHALL cause the transition to DUMP with timeout=0.
REQ-031 Otherwise, in RUN, cycle_cnt==MAX_CYCLES-1 SHALL cause the transition to DUMP with timeout=1.
REQ-032 If both end conditions hold in the same cycle, halt SHALL win and timeout SHALL be 0.
REQ-033 The PC record of the cycle in which the end condition is detected SHALL still be presented under the normal rules.
REQ-034 cpu_hold SHALL be 0 in RUN and 1 in DUMP, STAT and DONE.
REQ-035 In DUMP, reg_sel SHALL equal idx, which starts at 0.
REQ-036 In DUMP, whenever the slot is loadable, the block SHALL load {tag 01, data (idx==0 ? 0 : reg_data), aux idx zero-extended} and increment idx.
REQ-037 After loading the record for idx==NREG-1, the block SHALL go to STAT.
REQ-038 In DUMP, no record SHALL ever be dropped; backpressure SHALL stall idx.
REQ-039 In STAT, when the slot is loadable, the block SHALL load {tag 10, data cycle_cnt, aux {timeout, drop_cnt}} zero-extended to DW, then go to DONE.
REQ-040 In DONE, done SHALL be 1; the last record SHALL drain normally and no further records SHALL be produced.
REQ-041 The block SHALL remain in DONE until reset.
REQ-042 Outside DUMP, reg_sel SHALL be 0.

Reset
REQ-043 rstn=0 SHALL, asynchronously and at any time (including mid-DUMP with a record pending), clear the state to RUN and clear cycle_cnt, idx, drop_cnt, trace_valid, done, timeout, cpu_hold and reg_sel.
REQ-044 After reset the pending record SHALL be discarded, and trace_tag, trace_data and trace_aux SHALL be 0.
REQ-045 Operation SHALL resume on the first rising edge after rstn=1.

Verification
REQ-046 The bench SHALL cover halt: pc steps 0,4,...,0x48 with trace_ready=1 -> 19 PC records (pc 0..0x48), then 32 REG records (aux 0..31, r0 data 0), then STAT with data 18 and aux 0; done=1; cpu_hold=1 from the cycle after pc=0x48.
REQ-047 The bench SHALL cover timeout: MAX_CYCLES=20 and pc never reaching HALT_PC -> 20 PC records, then DUMP, then STAT with data 19 and aux bit DW-1 = 1 (timeout); timeout=1.
REQ-048 The bench SHALL cover backpressure: trace_ready=0 for 5 cycles in RUN -> 4 drops (drop_cnt=4), the held record unchanged; trace_ready toggling each cycle during DUMP -> all 32 REG records delivered in order with no gaps in aux.
REQ-049 The bench SHALL cover simultaneous end: MAX_CYCLES such that the timeout coincides with pc==HALT_PC -> timeout=0 and STAT aux bit DW-1 = 0.
REQ-050 The bench SHALL cover reset mid-DUMP: rstn low at idx=10 with trace_valid=1 -> trace_valid=0, cpu_hold=0, reg_sel=0 immediately (no clock edge needed); after release, cycle_cnt restarts at 0 in RUN.
REQ-051 The bench SHALL cover TRACE_EN=0: a halt at cycle 7 -> the first record seen is REG aux 0, and STAT data 7.

Source files
------------

// File: rtl/cpu_trace_monitor.sv
// Run-time trace monitor: streams PC records while the CPU runs, then freezes it,
// dumps the register file and emits a final status record through one handshake slot.
module cpu_trace_monitor #(
   parameter int unsigned     DW         = 32,
   parameter int unsigned     NREG       = 32,
   parameter int unsigned     RSW        = 5,
   parameter logic [DW-1:0]   HALT_PC    = DW'(32'h0000_0048),
   parameter int unsigned     MAX_CYCLES = 1000,
   parameter bit              TRACE_EN   = 1'b1
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic [DW-1:0]   pc,
   input  logic [DW-1:0]   instr,
   input  logic [DW-1:0]   reg_data,
   output logic [RSW-1:0]  reg_sel,
   output logic            cpu_hold,
   output logic            trace_valid,
   input  logic            trace_ready,
   output logic [1:0]      trace_tag,
   output logic [DW-1:0]   trace_data,
   output logic [DW-1:0]   trace_aux,
   output logic            done,
   output logic            timeout,
   output logic [15:0]     drop_cnt
);

   typedef enum logic [1:0] {
      ST_RUN,
      ST_DUMP,
      ST_STAT,
      ST_DONE
   } state_t;

   localparam logic [1:0] TAG_PC   = 2'b00;
   localparam logic [1:0] TAG_REG  = 2'b01;
   localparam logic [1:0] TAG_STAT = 2'b10;

   state_t           state;
   state_t           state_nxt;
   logic [31:0]      cycle_cnt;
   logic [RSW-1:0]   idx;

   logic             slot_free;
   logic             load;
   logic             drop;
   logic             idx_inc;
   logic             cyc_inc;
   logic             set_tmo;
   logic [1:0]       ld_tag;
   logic [DW-1:0]    ld_data;
   logic [DW-1:0]    ld_aux;

   // The slot may take a new record when empty or when its current record leaves this edge.
   assign slot_free = !trace_valid || trace_ready;

   assign cpu_hold = (state != ST_RUN);
   assign done     = (state == ST_DONE);
   assign reg_sel  = (state == ST_DUMP) ? idx : '0;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= ST_RUN;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      drop      = 1'b0;
      idx_inc   = 1'b0;
      cyc_inc   = 1'b0;
      set_tmo   = 1'b0;
      ld_tag    = TAG_PC;
      ld_data   = '0;
      ld_aux    = '0;
      case (state)
         ST_RUN: begin
            if (TRACE_EN) begin
               if (slot_free) begin
                  load    = 1'b1;
                  ld_tag  = TAG_PC;
                  ld_data = pc;
                  ld_aux  = instr;
               end else begin
                  drop = 1'b1;
               end
            end
            // Halt takes priority; the counter freezes on the cycle the run ends.
            if (pc == HALT_PC) begin
               state_nxt = ST_DUMP;
            end else if (cycle_cnt == 32'(MAX_CYCLES - 1)) begin
               state_nxt = ST_DUMP;
               set_tmo   = 1'b1;
            end else begin
               cyc_inc = 1'b1;
            end
         end
         ST_DUMP: begin
            if (slot_free) begin
               load    = 1'b1;
               ld_tag  = TAG_REG;
               ld_data = (idx == '0) ? '0 : reg_data;
               ld_aux  = DW'(idx);
               idx_inc = 1'b1;
               if (idx == RSW'(NREG - 1)) begin
                  state_nxt = ST_STAT;
               end
            end
         end
         ST_STAT: begin
            if (slot_free) begin
               load            = 1'b1;
               ld_tag          = TAG_STAT;
               ld_data         = DW'(cycle_cnt);
               ld_aux[DW-1]    = timeout;
               ld_aux[15:0]    = drop_cnt;
               state_nxt       = ST_DONE;
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cycle_cnt <= '0;
         idx       <= '0;
         drop_cnt  <= '0;
         timeout   <= 1'b0;
      end else begin
         if (cyc_inc) begin
            cycle_cnt <= cycle_cnt + 32'd1;
         end
         if (idx_inc) begin
            idx <= idx + RSW'(1);
         end
         if (drop && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
         end
         if (set_tmo) begin
            timeout <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         trace_valid <= 1'b0;
         trace_tag   <= '0;
         trace_data  <= '0;
         trace_aux   <= '0;
      end else if (load) begin
         trace_valid <= 1'b1;
         trace_tag   <= ld_tag;
         trace_data  <= ld_data;
         trace_aux   <= ld_aux;
      end else if (trace_valid && trace_ready) begin
         trace_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_cpu_trace_monitor.sv
// Bench for cpu_trace_monitor: four parameterisations share one stimulus stream and
// their delivered records are scored against a record-list model built from the stimulus.
module tb_cpu_trace_monitor;

   typedef struct packed {
      logic [1:0]  tag;
      logic [31:0] data;
      logic [31:0] aux;
   } rec_t;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [31:0] pc = '0;
   logic [31:0] instr = '0;
   logic        trace_ready = 1'b0;

   logic [31:0] rf [32];
   logic [31:0] rd [4];
   logic [4:0]  rs [4];
   logic        hold [4];
   logic        tv [4];
   logic        dn [4];
   logic        tmo [4];
   logic [1:0]  tt [4];
   logic [31:0] td [4];
   logic [31:0] ta [4];
   logic [15:0] dc [4];

   int vectors = 0;
   int miscompares = 0;

   logic [31:0] stim_pc [$];
   logic [31:0] stim_instr [$];
   bit          stim_rdy [$];
   rec_t        got_rec [$];
   int          got_inst [$];
   rec_t        got_i [$];
   rec_t        exp_q [$];
   int unsigned exp_drops;
   logic        exp_tmo;
   logic        obs_hold [$];
   logic        obs_tv [$];
   logic [31:0] obs_data [$];
   logic [31:0] obs_aux [$];

   always #5 clk = ~clk;

   assign rd[0] = rf[rs[0]];
   assign rd[1] = rf[rs[1]];
   assign rd[2] = rf[rs[2]];
   assign rd[3] = rf[rs[3]];

   // 0: defaults, 1: unreachable halt with MAX_CYCLES=20, 2: trace off with halt at 0x1C,
   // 3: MAX_CYCLES=19 so timeout and halt at 0x48 coincide.
   cpu_trace_monitor u0 (
      .clk(clk), .rstn(rstn), .pc(pc), .instr(instr), .reg_data(rd[0]), .reg_sel(rs[0]),
      .cpu_hold(hold[0]), .trace_valid(tv[0]), .trace_ready(trace_ready), .trace_tag(tt[0]),
      .trace_data(td[0]), .trace_aux(ta[0]), .done(dn[0]), .timeout(tmo[0]), .drop_cnt(dc[0]));

   cpu_trace_monitor #(.HALT_PC(32'hFFFF_FFF0), .MAX_CYCLES(20)) u1 (
      .clk(clk), .rstn(rstn), .pc(pc), .instr(instr), .reg_data(rd[1]), .reg_sel(rs[1]),
      .cpu_hold(hold[1]), .trace_valid(tv[1]), .trace_ready(trace_ready), .trace_tag(tt[1]),
      .trace_data(td[1]), .trace_aux(ta[1]), .done(dn[1]), .timeout(tmo[1]), .drop_cnt(dc[1]));

   cpu_trace_monitor #(.HALT_PC(32'h0000_001C), .TRACE_EN(1'b0)) u2 (
      .clk(clk), .rstn(rstn), .pc(pc), .instr(instr), .reg_data(rd[2]), .reg_sel(rs[2]),
      .cpu_hold(hold[2]), .trace_valid(tv[2]), .trace_ready(trace_ready), .trace_tag(tt[2]),
      .trace_data(td[2]), .trace_aux(ta[2]), .done(dn[2]), .timeout(tmo[2]), .drop_cnt(dc[2]));

   cpu_trace_monitor #(.MAX_CYCLES(19)) u3 (
      .clk(clk), .rstn(rstn), .pc(pc), .instr(instr), .reg_data(rd[3]), .reg_sel(rs[3]),
      .cpu_hold(hold[3]), .trace_valid(tv[3]), .trace_ready(trace_ready), .trace_tag(tt[3]),
      .trace_data(td[3]), .trace_aux(ta[3]), .done(dn[3]), .timeout(tmo[3]), .drop_cnt(dc[3]));

   // Inputs change just after the rising edge, so mid-cycle values are what the next edge sees.
   always @(negedge clk) begin
      if (rstn) begin
         for (int i = 0; i < 4; i++) begin
            if (tv[i] && trace_ready) begin
               got_rec.push_back({tt[i], td[i], ta[i]});
               got_inst.push_back(i);
            end
         end
      end
   end

   function automatic logic [31:0] halt_of(int i);
      case (i)
         1: halt_of = 32'hFFFF_FFF0;
         2: halt_of = 32'h0000_001C;
         default: halt_of = 32'h0000_0048;
      endcase
   endfunction

   function automatic int max_of(int i);
      case (i)
         1: max_of = 20;
         3: max_of = 19;
         default: max_of = 1000;
      endcase
   endfunction

   // Expected delivered record list: the run ends at the first halt PC or the last allowed
   // cycle; the slot is empty only on cycle 0, later PC records survive only if the sink is ready.
   function automatic void build_exp(int i);
      int e;
      int unsigned drops;
      e = -1;
      drops = 0;
      exp_q.delete();
      for (int k = 0; k < stim_pc.size(); k++) begin
         if (e < 0 && (stim_pc[k] == halt_of(i) || k == max_of(i) - 1)) e = k;
      end
      if (e < 0) e = stim_pc.size() - 1;
      exp_tmo = (stim_pc[e] != halt_of(i));
      for (int k = 0; k <= e; k++) begin
         if (i != 2) begin
            if (k == 0 || stim_rdy[k]) exp_q.push_back({2'b00, stim_pc[k], stim_instr[k]});
            else drops++;
         end
      end
      for (int r = 0; r < 32; r++) begin
         exp_q.push_back({2'b01, (r == 0) ? 32'h0 : rf[r], 32'(r)});
      end
      exp_q.push_back({2'b10, 32'(e), {exp_tmo, 15'h0, 16'(drops)}});
      exp_drops = drops;
   endfunction

   function automatic void pick(int i);
      got_i.delete();
      for (int j = 0; j < got_rec.size(); j++) begin
         if (got_inst[j] == i) got_i.push_back(got_rec[j]);
      end
   endfunction

   function automatic void fill_rf();
      for (int r = 0; r < 32; r++) rf[r] = $urandom();
   endfunction

   // mode 0: pc=4k, always ready; 1: stall 5 cycles, then ready, toggling from DUMP; 2: random
   function automatic void gen_stim(int n, int mode);
      logic [31:0] p;
      bit r;
      stim_pc.delete();
      stim_instr.delete();
      stim_rdy.delete();
      for (int k = 0; k < n; k++) begin
         case (mode)
            0: begin p = 32'(4 * k); r = 1'b1; end
            1: begin p = 32'(4 * k); r = (k < 5) ? 1'b0 : ((k < 19) ? 1'b1 : (k % 2 == 1)); end
            default: begin p = 32'($urandom_range(0, 31)) * 32'd4; r = ($urandom_range(0, 9) < 6); end
         endcase
         if (mode == 2 && k == 40) p = 32'h1C;
         if (mode == 2 && k == 60) p = 32'h48;
         stim_pc.push_back(p);
         stim_instr.push_back($urandom());
         stim_rdy.push_back(r);
      end
   endfunction

   task automatic do_reset();
      rstn = 1'b0;
      trace_ready = 1'b0;
      pc = '0;
      instr = '0;
      repeat (3) @(posedge clk);
      #1;
      rstn = 1'b1;
      got_rec.delete();
      got_inst.delete();
      obs_hold.delete();
      obs_tv.delete();
      obs_data.delete();
      obs_aux.delete();
   endtask

   task automatic drive(int n);
      for (int k = 0; k < n; k++) begin
         pc = stim_pc[k];
         instr = stim_instr[k];
         trace_ready = stim_rdy[k];
         @(posedge clk);
         #1;
         obs_hold.push_back(hold[0]);
         obs_tv.push_back(tv[0]);
         obs_data.push_back(td[0]);
         obs_aux.push_back(ta[0]);
      end
   endtask

   task automatic run_linear();
      fill_rf();
      gen_stim(120, 0);
      do_reset();
      drive(120);
   endtask

   task automatic test_reset();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         vectors++;
         if ({tv[i], tt[i], td[i], ta[i]} !== 67'h0) begin
            miscompares++;
            $display("FAIL reset_slot[%0d]: got %h expected 0", i, {tv[i], tt[i], td[i], ta[i]});
         end
         vectors++;
         if ({hold[i], rs[i], dn[i], tmo[i], dc[i]} !== 24'h0) begin
            miscompares++;
            $display("FAIL reset_status[%0d]: got %h expected 0", i, {hold[i], rs[i], dn[i], tmo[i], dc[i]});
         end
      end
   endtask

   task automatic test_halt();
      int npc;
      run_linear();
      pick(0);
      build_exp(0);
      vectors++;
      if (got_i.size() != exp_q.size()) begin
         miscompares++;
         $display("FAIL halt_len: got %0d records expected %0d", got_i.size(), exp_q.size());
      end
      for (int j = 0; j < got_i.size() && j < exp_q.size(); j++) begin
         vectors++;
         if (got_i[j] !== exp_q[j]) begin
            miscompares++;
            $display("FAIL halt_rec[%0d]: got %h expected %h", j, got_i[j], exp_q[j]);
         end
      end
      npc = 0;
      foreach (got_i[j]) if (got_i[j].tag == 2'b00) npc++;
      vectors++;
      if (npc != 19) begin
         miscompares++;
         $display("FAIL halt_pc_count: got %0d expected 19", npc);
      end
      vectors++;
      if (got_i.size() == 0 || got_i[got_i.size() - 1] !== {2'b10, 32'd18, 32'd0}) begin
         miscompares++;
         $display("FAIL halt_stat: got %0d records, last differs from STAT 18/0", got_i.size());
      end
      vectors++;
      if (obs_hold[17] !== 1'b0 || obs_hold[18] !== 1'b1) begin
         miscompares++;
         $display("FAIL halt_hold: got %b%b expected 01", obs_hold[17], obs_hold[18]);
      end
      vectors++;
      if ({dn[0], tmo[0], dc[0]} !== {1'b1, 1'b0, 16'h0}) begin
         miscompares++;
         $display("FAIL halt_flags: got %h expected %h", {dn[0], tmo[0], dc[0]}, {1'b1, 1'b0, 16'h0});
      end
   endtask

   task automatic test_timeout();
      run_linear();
      pick(1);
      build_exp(1);
      vectors++;
      if (got_i.size() != exp_q.size()) begin
         miscompares++;
         $display("FAIL timeout_len: got %0d records expected %0d", got_i.size(), exp_q.size());
      end
      for (int j = 0; j < got_i.size() && j < exp_q.size(); j++) begin
         vectors++;
         if (got_i[j] !== exp_q[j]) begin
            miscompares++;
            $display("FAIL timeout_rec[%0d]: got %h expected %h", j, got_i[j], exp_q[j]);
         end
      end
      vectors++;
      if (got_i.size() != 53 || got_i[52] !== {2'b10, 32'd19, 32'h8000_0000}) begin
         miscompares++;
         $display("FAIL timeout_stat: got %0d records, expected 53 ending STAT 19/80000000", got_i.size());
      end
      vectors++;
      if ({dn[1], tmo[1]} !== 2'b11) begin
         miscompares++;
         $display("FAIL timeout_flags: got %b%b expected 11", dn[1], tmo[1]);
      end
   endtask

   task automatic test_simultaneous();
      run_linear();
      pick(3);
      build_exp(3);
      vectors++;
      if (got_i.size() != exp_q.size()) begin
         miscompares++;
         $display("FAIL simul_len: got %0d records expected %0d", got_i.size(), exp_q.size());
      end
      for (int j = 0; j < got_i.size() && j < exp_q.size(); j++) begin
         vectors++;
         if (got_i[j] !== exp_q[j]) begin
            miscompares++;
            $display("FAIL simul_rec[%0d]: got %h expected %h", j, got_i[j], exp_q[j]);
         end
      end
      vectors++;
      if (got_i.size() == 0 || got_i[got_i.size() - 1] !== {2'b10, 32'd18, 32'd0}) begin
         miscompares++;
         $display("FAIL simul_stat: got %0d records, last differs from STAT 18/0", got_i.size());
      end
      vectors++;
      if (tmo[3] !== 1'b0) begin
         miscompares++;
         $display("FAIL simul_timeout: got %b expected 0", tmo[3]);
      end
   endtask

   task automatic test_trace_off();
      run_linear();
      pick(2);
      build_exp(2);
      vectors++;
      if (got_i.size() != exp_q.size()) begin
         miscompares++;
         $display("FAIL traceoff_len: got %0d records expected %0d", got_i.size(), exp_q.size());
      end
      for (int j = 0; j < got_i.size() && j < exp_q.size(); j++) begin
         vectors++;
         if (got_i[j] !== exp_q[j]) begin
            miscompares++;
            $display("FAIL traceoff_rec[%0d]: got %h expected %h", j, got_i[j], exp_q[j]);
         end
      end
      vectors++;
      if (got_i.size() != 33 || got_i[0] !== {2'b01, 32'd0, 32'd0} || got_i[32] !== {2'b10, 32'd7, 32'd0}) begin
         miscompares++;
         $display("FAIL traceoff_ends: got %0d records, expected 33 from REG 0 to STAT 7", got_i.size());
      end
      vectors++;
      if (dc[2] !== 16'h0) begin
         miscompares++;
         $display("FAIL traceoff_drops: got %0d expected 0", dc[2]);
      end
   endtask

   task automatic test_backpressure();
      int nreg;
      fill_rf();
      gen_stim(200, 1);
      do_reset();
      drive(200);
      for (int k = 0; k < 5; k++) begin
         vectors++;
         if ({obs_tv[k], obs_data[k], obs_aux[k]} !== {1'b1, stim_pc[0], stim_instr[0]}) begin
            miscompares++;
            $display("FAIL bp_held[%0d]: got %h expected %h", k,
                     {obs_tv[k], obs_data[k], obs_aux[k]}, {1'b1, stim_pc[0], stim_instr[0]});
         end
      end
      vectors++;
      if (dc[0] !== 16'd4) begin
         miscompares++;
         $display("FAIL bp_drops: got %0d expected 4", dc[0]);
      end
      pick(0);
      build_exp(0);
      vectors++;
      if (got_i.size() != exp_q.size()) begin
         miscompares++;
         $display("FAIL bp_len: got %0d records expected %0d", got_i.size(), exp_q.size());
      end
      for (int j = 0; j < got_i.size() && j < exp_q.size(); j++) begin
         vectors++;
         if (got_i[j] !== exp_q[j]) begin
            miscompares++;
            $display("FAIL bp_rec[%0d]: got %h expected %h", j, got_i[j], exp_q[j]);
         end
      end
      nreg = 0;
      foreach (got_i[j]) begin
         if (got_i[j].tag == 2'b01) begin
            vectors++;
            if (got_i[j].aux !== 32'(nreg)) begin
               miscompares++;
               $display("FAIL bp_reg_order: got aux %0d expected %0d", got_i[j].aux, nreg);
            end
            nreg++;
         end
      end
      vectors++;
      if (nreg != 32) begin
         miscompares++;
         $display("FAIL bp_reg_count: got %0d expected 32", nreg);
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 4; it++) begin
         fill_rf();
         gen_stim(300, 2);
         do_reset();
         drive(300);
         for (int i = 0; i < 4; i++) begin
            pick(i);
            build_exp(i);
            vectors++;
            if (got_i.size() != exp_q.size()) begin
               miscompares++;
               $display("FAIL rand_len[%0d.%0d]: got %0d records expected %0d", it, i, got_i.size(), exp_q.size());
            end
            for (int j = 0; j < got_i.size() && j < exp_q.size(); j++) begin
               vectors++;
               if (got_i[j] !== exp_q[j]) begin
                  miscompares++;
                  $display("FAIL rand_rec[%0d.%0d.%0d]: got %h expected %h", it, i, j, got_i[j], exp_q[j]);
               end
            end
            vectors++;
            if ({dn[i], tmo[i], dc[i]} !== {1'b1, exp_tmo, 16'(exp_drops)}) begin
               miscompares++;
               $display("FAIL rand_flags[%0d.%0d]: got %h expected %h", it, i,
                        {dn[i], tmo[i], dc[i]}, {1'b1, exp_tmo, 16'(exp_drops)});
            end
         end
      end
   endtask

   task automatic test_reset_mid_dump();
      int k;
      bit found;
      fill_rf();
      gen_stim(120, 0);
      do_reset();
      k = 0;
      found = 1'b0;
      while (!found && k < 120) begin
         pc = stim_pc[k];
         instr = stim_instr[k];
         trace_ready = stim_rdy[k];
         @(posedge clk);
         #1;
         if (rs[0] == 5'd10) found = 1'b1;
         k++;
      end
      vectors++;
      if (!found || tv[0] !== 1'b1) begin
         miscompares++;
         $display("FAIL mid_dump_reach: got found=%b valid=%b expected 1 1", found, tv[0]);
      end
      #2;
      rstn = 1'b0;
      #1;
      vectors++;
      if ({tv[0], hold[0], rs[0]} !== 7'h0) begin
         miscompares++;
         $display("FAIL mid_dump_async: got %h expected 0", {tv[0], hold[0], rs[0]});
      end
      vectors++;
      if ({tt[0], td[0], ta[0], dn[0]} !== 67'h0) begin
         miscompares++;
         $display("FAIL mid_dump_slot: got %h expected 0", {tt[0], td[0], ta[0], dn[0]});
      end
      run_linear();
      pick(0);
      build_exp(0);
      vectors++;
      if (got_i.size() != exp_q.size()) begin
         miscompares++;
         $display("FAIL mid_dump_len: got %0d records expected %0d", got_i.size(), exp_q.size());
      end
      for (int j = 0; j < got_i.size() && j < exp_q.size(); j++) begin
         vectors++;
         if (got_i[j] !== exp_q[j]) begin
            miscompares++;
            $display("FAIL mid_dump_rec[%0d]: got %h expected %h", j, got_i[j], exp_q[j]);
         end
      end
      vectors++;
      if (got_i.size() == 0 || got_i[got_i.size() - 1] !== {2'b10, 32'd18, 32'd0}) begin
         miscompares++;
         $display("FAIL mid_dump_restart: got %0d records, last differs from STAT 18/0", got_i.size());
      end
   endtask

   initial begin
      test_reset();
      test_halt();
      test_timeout();
      test_simultaneous();
      test_trace_off();
      test_backpressure();
      test_random();
      test_reset_mid_dump();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
